instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL declare parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The module SHALL declare parameter DEPTH, default 4, meaning prefetch buffer entries; legal values are powers of two, 2..16.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port A, output, 32 bits: word-aligned address to the instruction memory.
REQ-006 The module SHALL have port RD, input, 32 bits: instruction word returned combinationally for A in the same cycle.
REQ-007 The module SHALL have port instr, output, 32 bits: instruction at the buffer head.
REQ-008 The module SHALL have port pc, output, 32 bits: address of instr.
REQ-009 The module SHALL have port pc_plus8, output, 32 bits: pc + 8, the architectural ARM PC read value.
REQ-010 The module SHALL have port valid, output, 1 bit: instr/pc are meaningful.
REQ-011 The module SHALL have port ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 The module SHALL have port branch_taken, input, 1 bit: redirect request.
REQ-013 The module SHALL have port branch_target, input, 32 bits: redirect address.

Function
REQ-014 The module SHALL hold fetch_pc; A SHALL equal fetch_pc at all times, with bits [1:0] always 0.
REQ-015 The module SHALL define push = !branch_taken && (count < DEPTH || pop), and pop = valid && ready && !branch_taken.
REQ-016 On push, the module SHALL write {fetch_pc, RD} to the tail and advance fetch_pc by 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-017 valid SHALL be high iff count > 0; instr/pc/pc_plus8 SHALL be driven from the head entry with no combinational path from RD.
REQ-018 Fetch latency: an address presented on A SHALL appear on instr one cycle later if the buffer was empty.
REQ-019 On pop, the module SHALL advance the head; simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-020 When full and not popping, the module SHALL neither push nor change fetch_pc.
REQ-021 When empty, the module SHALL ignore ready (no pop, no underflow).
REQ-022 On branch_taken in cycle N, the module SHALL, at the edge ending N, empty the buffer (count = 0), set fetch_pc = {branch_target[31:2], 2'b00}, and discard that cycle's push and pop.
REQ-023 After a redirect, valid SHALL be low in cycle N+1, and the target instruction SHALL be valid in N+2.
REQ-024 pc_plus8 SHALL wrap modulo 2^32.
REQ-025 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-026 While reset is low, the module SHALL hold fetch_pc = RESET_PC, count = 0, pointers = 0, valid = 0, and instr/pc/pc_plus8 = 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries immediately, regardless of clk.
REQ-028 The first push SHALL occur in the first clk cycle after reset deasserts, from RESET_PC.

Configuration
REQ-029 With macro IFETCH_STALL_CNT_EN defined, the module SHALL add output stall_cnt (32 bits), which increments each cycle with valid && !ready && !branch_taken, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-030 Without IFETCH_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-031 Package fetch_pkg SHALL hold typedef fetch_entry_t {pc[31:0], instr[31:0]}, constant INSTR_BYTES = 4, and constant PC_READ_OFFSET = 8.
REQ-032 The buffer SHALL be a sub-module fetch_fifo (DEPTH, fetch_entry_t, push/pop/flush, count) instantiated once; the PC logic stays in instruction_fetch.

Verification
REQ-033 Reset release, ready = 1, memory word[i] = i: A SHALL be 0,4,8,… and instr SHALL be 0,1,2,…, valid from cycle 2, with pc_plus8 = pc + 8.
REQ-034 ready = 0 for 10 cycles from reset: count SHALL saturate at 4, A SHALL hold at 0x10, and entries 0..3 SHALL be delivered in order once ready = 1.
REQ-035 branch_taken with target 0x43 while the buffer is full: the next cycle SHALL have valid = 0 and A = 0x40, then instr = word[16] with pc = 0x40.
REQ-036 RESET_PC = 0xFFFF_FFF8, ready = 1: fetch addresses SHALL be FFF8, FFFC, 0000, and pc_plus8 at pc = FFFC SHALL be 0x4.
REQ-037 reset pulsed low mid-stream with 3 entries buffered: valid SHALL drop asynchronously, and the restart SHALL begin at RESET_PC.
REQ-038 With IFETCH_STALL_CNT_EN defined, 7 stall cycles followed by a branch: stall_cnt SHALL equal 7 and SHALL NOT increment during the branch cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES    = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular queue of {pc, instr} with a single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  // Pointer, occupancy and storage update; flush beats any push/pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        mem_r[tail_r] <= wdata;
        tail_r        <= tail_r + PW'(1);
      end
      if (pop) begin
        head_r <= head_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[head_r];
  assign count = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC sequencing, branch redirect and prefetch buffer front end.
// Optional feature: define IFETCH_STALL_CNT_EN to add the saturating stall_cnt output.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] A,
  input  logic [31:0] RD,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        valid,
  input  logic        ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int          CW          = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_ALIGN = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_r;
  logic [CW-1:0] count_s;
  logic          valid_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  wdata_s;
  fetch_entry_t  head_s;

  // Handshake: a pop frees a slot, so a full buffer can still accept this cycle's word.
  always_comb begin
    valid_s = (count_s != CW'(0));
    pop_s   = valid_s && ready && !branch_taken;
    push_s  = !branch_taken && ((count_s < CW'(DEPTH)) || pop_s);
    wdata_s = '{pc: fetch_pc_r, instr: RD};
  end

  // Fetch PC sequencing; a redirect wins over sequential advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_ALIGN;
    end else if (branch_taken) begin
      fetch_pc_r <= {branch_target[31:2], 2'b00};
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + INSTR_BYTES;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (branch_taken),
    .wdata (wdata_s),
    .head  (head_s),
    .count (count_s)
  );

  // Head outputs are forced to zero while empty so reset and flushed state read as all-zero.
  always_comb begin
    if (valid_s) begin
      instr    = head_s.instr;
      pc       = head_s.pc;
      pc_plus8 = head_s.pc + PC_READ_OFFSET;
    end else begin
      instr    = 32'd0;
      pc       = 32'd0;
      pc_plus8 = 32'd0;
    end
  end

  assign A     = fetch_pc_r;
  assign valid = valid_s;

`ifdef IFETCH_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (valid_s && !ready && !branch_taken && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; memory model returns word[i] = i.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] a, rd, instr, pc, pc_plus8;
  logic        valid;
  logic [31:0] a_w, rd_w, instr_w, pc_w, pc_plus8_w;
  logic        valid_w;
  logic        ready_w = 1'b1;
  logic        bt_w    = 1'b0;
  logic [31:0] tgt_w   = 32'd0;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_w;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rd   = {2'b00, a[31:2]};
  assign rd_w = {2'b00, a_w[31:2]};

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .A             (a),
    .RD            (rd),
    .instr         (instr),
    .pc            (pc),
    .pc_plus8      (pc_plus8),
    .valid         (valid),
    .ready         (ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk           (clk),
    .reset         (reset),
    .A             (a_w),
    .RD            (rd_w),
    .instr         (instr_w),
    .pc            (pc_w),
    .pc_plus8      (pc_plus8_w),
    .valid         (valid_w),
    .ready         (ready_w),
    .branch_taken  (bt_w),
    .branch_target (tgt_w)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt_w)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] epc_w;
    reset         = 1'b0;
    ready         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_pc8", pc_plus8, 32'd0);
    check("rst_A", a, 32'd0);
    check("rst_A_w", a_w, 32'hFFFF_FFF8);
    reset = 1'b1;

    // Streaming with ready high; wrap instance alongside
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("str_valid", {31'd0, valid}, 32'd1);
      check("str_instr", instr, 32'(k));
      check("str_pc", pc, 32'(4 * k));
      check("str_pc8", pc_plus8, 32'(4 * k + 8));
      check("str_A", a, 32'(4 * k + 4));
      epc_w = 32'hFFFF_FFF8 + 32'(4 * k);
      check("wrap_pc", pc_w, epc_w);
      check("wrap_A", a_w, epc_w + 32'd4);
      check("wrap_pc8", pc_plus8_w, epc_w + 32'd8);
      check("wrap_instr", instr_w, {2'b00, epc_w[31:2]});
    end
    check("wrap_pc8_at_fffc_reached", {31'd0, valid_w}, 32'd1);

    // Back-pressure: buffer fills, fetch holds at 0x10, then drains in order
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b0;
    #1;
    check("bp_rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_valid", {31'd0, valid}, 32'd1);
    check("bp_A_hold", a, 32'h10);
    check("bp_head", instr, 32'd0);
    ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("bp_instr", instr, 32'(k));
      check("bp_pc", pc, 32'(4 * k));
      check("bp_A", a, 32'(16 + 4 * k));
    end

    // Branch while full after 7 stall cycles
    @(negedge clk);
    reset = 1'b0;
    ready = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("br_full_A", a, 32'h10);
    check("br_full_valid", {31'd0, valid}, 32'd1);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_7", stall_cnt, 32'd7);
`endif
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    @(negedge clk);
    branch_taken = 1'b0;
    check("br_n1_valid", {31'd0, valid}, 32'd0);
    check("br_n1_A", a, 32'h40);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_br", stall_cnt, 32'd7);
`endif
    @(negedge clk);
    check("br_n2_valid", {31'd0, valid}, 32'd1);
    check("br_n2_instr", instr, 32'd16);
    check("br_n2_pc", pc, 32'h40);
    check("br_n2_A", a, 32'h44);
`ifdef IFETCH_STALL_CNT_EN
    check("stall_after", stall_cnt, 32'd7);
`endif

    // Asynchronous reset mid-stream with 3 entries buffered
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_pre_valid", {31'd0, valid}, 32'd1);
    check("ar_pre_A", a, 32'h0C);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", {31'd0, valid}, 32'd0);
    check("ar_A", a, 32'd0);
    check("ar_instr", instr, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ar_restart_valid", {31'd0, valid}, 32'd1);
    check("ar_restart_pc", pc, 32'd0);
    check("ar_restart_A", a, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
